ashift_seq_32bit: RTL and testbench

Multi-cycle 32-bit shift unit for the ALU logic group. It accepts an operand, a shift amount and a direction over a valid/ready handshake. It shifts one bit position per clock, either arithmetic right (sign fill) or logical left (zero fill). It then presents the result and the last bit shifted out until the consumer accepts them. The unit serves ALU shift instructions whose amount comes from a register field, so the datapath needs no 32x5 barrel network.

---
 rtl/ashift_pkg.sv | 17 +
 rtl/ashift_step.sv | 23 ++
 rtl/ashift_seq_32bit.sv | 82 ++++++++
 tb/tb_ashift_seq_32bit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ashift_pkg.sv
// Shared definitions for the sequential arithmetic/logical shift unit:
// default widths, FSM state encoding and direction codes.
package ashift_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT_ARITH = 1'b0;
    localparam logic DIR_LEFT        = 1'b1;

endpackage

// File: rtl/ashift_step.sv
// One-position shifter: arithmetic right (sign fill) or logical left (zero fill),
// also reporting the bit that falls off the end.
module ashift_step
    import ashift_pkg::*;
#(
    parameter int WIDTH = ashift_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic             dir,
    output logic [WIDTH-1:0] acc_next,
    output logic             bit_out
);

    always_comb begin
        acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
        bit_out  = acc[0];
        if (dir == DIR_LEFT) begin
            acc_next = {acc[WIDTH-2:0], 1'b0};
            bit_out  = acc[WIDTH-1];
        end
    end

endmodule

// File: rtl/ashift_seq_32bit.sv
// Multi-cycle shift unit: accepts an operand over valid/ready, shifts one bit
// per clock, then holds the result and last shifted-out bit until consumed.
module ashift_seq_32bit
    import ashift_pkg::*;
#(
    parameter int WIDTH = ashift_pkg::WIDTH,
    parameter int SHW   = ashift_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] D,
    input  logic [SHW-1:0]   AMT,
    input  logic             DIR,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CO
);

    state_t           state, state_next;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic             dir_r;
    logic             co;

    logic [WIDTH-1:0] step_acc;
    logic             step_bit;

    ashift_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .dir      (dir_r),
        .acc_next (step_acc),
        .bit_out  (step_bit)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (AMT != '0) ? SHIFT : HOLD;
            SHIFT:   if (cnt == SHW'(1)) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset clears the datapath too, so an aborted operation never leaves a stale S/CO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            dir_r <= DIR_RIGHT_ARITH;
            co    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= D;
                        cnt   <= AMT;
                        dir_r <= DIR;
                        co    <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc <= step_acc;
                    co  <= step_bit;
                    cnt <= cnt - SHW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign S         = acc;
    assign CO        = co;

endmodule

// File: tb/tb_ashift_seq_32bit.sv
// Bench for ashift_seq_32bit: directed vector table, multi-cycle corner
// sequences (back-pressure, reset abort) and randomized ops against a model.
module tb_ashift_seq_32bit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  D = '0;
    logic [4:0]    AMT = '0;
    logic          DIR = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  S;
    logic          CO;

    int checks = 0;
    int errors = 0;

    ashift_seq_32bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .AMT       (AMT),
        .DIR       (DIR),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .CO        (CO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [4:0]   amt;
        logic         dir;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word shift by the full amount, last bit out picked from the operand.
    function automatic logic [W-1:0] model_s(input logic [W-1:0] d, input int amt, input logic dir);
        if (dir) return d << amt;
        return $unsigned($signed(d) >>> amt);
    endfunction

    function automatic logic model_co(input logic [W-1:0] d, input int amt, input logic dir);
        if (amt == 0) return 1'b0;
        if (dir) return d[W - amt];
        return d[amt - 1];
    endfunction

    task automatic issue(input logic [W-1:0] d, input logic [4:0] amt, input logic dir);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        D = d;
        AMT = amt;
        DIR = dir;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(input int amt, input logic [W-1:0] exp_s, input logic exp_co,
                               input string name);
        for (int i = 0; i < amt; i++) begin
            @(negedge clk);
            chk({name, "_early_valid"}, {31'd0, out_valid}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_S"}, S, exp_s);
        chk({name, "_CO"}, {31'd0, CO}, {31'd0, exp_co});
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_released_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_released_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        logic [W-1:0] rd;
        int ra;
        logic rdir;

        vecs[0] = '{32'h8000_0010, 5'd4,  1'b0, 32'hF800_0001, 1'b0};
        vecs[1] = '{32'h0000_0003, 5'd31, 1'b1, 32'h8000_0000, 1'b1};
        vecs[2] = '{32'h4000_0000, 5'd31, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b0};
        vecs[4] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b0};
        vecs[5] = '{32'hFFFF_0000, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{32'h7FFF_FFFF, 5'd31, 1'b0, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h8000_0001, 5'd1,  1'b1, 32'h0000_0002, 1'b1};

        // Reset state
        #12;
        chk("reset_S", S, 32'd0);
        chk("reset_CO", {31'd0, CO}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].d, vecs[i].amt, vecs[i].dir);
            wait_result(int'(vecs[i].amt), vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Back-pressure: result held, new request waits until release
        issue(32'h8000_0010, 5'd4, 1'b0);
        wait_result(4, 32'hF800_0001, 1'b0, "bp");
        in_valid = 1'b1;
        D = 32'h4000_0005;
        AMT = 5'd2;
        DIR = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_S", S, 32'hF800_0001);
            chk("bp_hold_CO", {31'd0, CO}, 32'd0);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(2, 32'h0000_0014, 1'b1, "bp_pending");
        release_result("bp_pending");

        // Reset abort during SHIFT with three steps remaining
        issue(32'h8000_0000, 5'd6, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_S", S, 32'd0);
        chk("abort_CO", {31'd0, CO}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_stays_invalid", {31'd0, out_valid}, 32'd0);
        issue(32'h0000_0001, 5'd5, 1'b1);
        wait_result(5, 32'h0000_0020, 1'b0, "post_reset");
        release_result("post_reset");

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rd = $urandom;
            ra = $urandom_range(0, 31);
            rdir = 1'($urandom_range(0, 1));
            issue(rd, 5'(ra), rdir);
            wait_result(ra, model_s(rd, ra, rdir), model_co(rd, ra, rdir),
                        $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_result($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
